alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Initiator side of the ALU operand/result interface. Buffers incoming ALU commands (in1, in2, op) in a small FIFO and drives them one at a time onto the ALU operand bus. Waits the ALU's fixed latency, then captures out/carryout/overflow and presents them on a valid/ready response port. Sits between any command source (test sequencer, microcode, host bridge) and the clocked ALU.

Parameters:
CMD_DEPTH, 4, command FIFO depth in entries; power of 2, >= 2
ALU_LAT, 1, ALU cycles from operand edge to registered result; 0 = combinational ALU

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_in1  in  8  operand A
cmd_in2  in  8  operand B
cmd_op  in  4  opcode
alu_in1  out  8  registered operand A to ALU
alu_in2  out  8  registered operand B to ALU
alu_op  out  4  registered opcode to ALU
alu_out  in  8  ALU result
alu_carryout  in  1  ALU carry
alu_overflow  in  1  ALU signed overflow
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  captured result
rsp_carry  out  1  captured carry
rsp_ovf  out  1  captured overflow
rsp_op  out  4  opcode echo for the response
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst low, async): FIFO emptied; FSM -> IDLE; alu_in1/alu_in2/alu_op, rsp_data/rsp_carry/rsp_ovf/rsp_op, rsp_valid, busy = 0. cmd_ready = 1, because FIFO is empty.
- Push: on cmd_valid && cmd_ready. cmd_ready depends only on full. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE, FIFO not empty: on the edge, pop the head entry, load alu_in1/alu_in2/alu_op, load wait counter = ALU_LAT, go to WAIT.
- IDLE, FIFO empty: alu_* hold their last values.
- A command pushed into an empty FIFO is popped no earlier than the next edge. There is no bypass.
- WAIT: decrement the counter each edge. On the edge where the counter is 0, do all of the following in the same edge:
  - sample alu_out/alu_carryout/alu_overflow into rsp_*;
  - copy alu_op to rsp_op;
  - set rsp_valid = 1;
  - go to RESP.
- Result sampling therefore occurs on edge E0+ALU_LAT+1, where E0 is the operand-load edge.
- RESP: hold rsp_* and alu_* stable while rsp_ready = 0. On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
- Throughput: one command per ALU_LAT+3 cycles when rsp_ready is tied high.
- alu_* are stable from E0 until the next pop.
- Opcodes are forwarded unmodified, including unused encodings 1110/1111. The sequencer does not interpret op.
- Ordering: responses are strictly in command order. No command is dropped or duplicated.
- Reset mid-operation: the in-flight command and all FIFO contents are discarded. No response is produced for them.
- FIFO pointers: log2(CMD_DEPTH)+1 bits, wrap naturally. full = MSBs differ and LSBs are equal.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- Defined: adds three outputs, each reset to 0:
  - stat_cmds[15:0]: increments on each response handshake;
  - stat_carry[15:0]: increments on a handshake with rsp_carry = 1;
  - stat_ovf[15:0]: increments on a handshake with rsp_ovf = 1.
  - All three saturate at 16'hFFFF.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package alu_seq_pkg holds:
  - DATA_W = 8 and OP_W = 4;
  - opcode constants (OP_ADD = 4'b0000, OP_SUB = 4'b0001, ...);
  - FSM state encodings IDLE/WAIT/RESP.
- One sub-module, alu_cmd_fifo: synchronous FIFO of width DATA_W*2+OP_W and depth CMD_DEPTH, with push/pop/full/empty and async active-low reset.
- The FSM, operand registers and response registers stay in the top module.

Test Plan:
1. ALU_LAT=1; push in1=25, in2=18, op=0000 (ADD) -> alu_* load on E0; rsp_valid rises on E0+2 with rsp_data=43, rsp_carry=0, rsp_ovf=0, rsp_op=0000.
2. CMD_DEPTH=4, rsp_ready=0; offer 6 back-to-back commands:
   - the 1st pops to the ALU and commands 2-5 fill the FIFO;
   - cmd_ready=0 after the 5th accept, so the 6th stalls;
   - after rsp_ready=1, all 6 responses arrive in order.
3. Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_* and alu_* unchanged, FIFO count unchanged, busy=1.
4. ADD 100+100 -> rsp_data=200, ovf=1, carry=0. ADD 200+100 -> rsp_data=44, carry=1.
5. Assert rst during WAIT with 2 commands queued -> all outputs 0 immediately, cmd_ready=1. After release, a fresh command 25+18 returns 43 and no stale response appears.
6. With ALU_SEQ_STATS_EN: run 3 commands, exactly one of which produces a carry -> stat_cmds=3, stat_carry=1, stat_ovf=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared widths, opcode constants, FSM encodings and the command record for the
// ALU command sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int CMD_W  = 2 * DATA_W + OP_W;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in1;
  } alu_cmd_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB read/write pointers; push is refused
// while full and pop is ignored while empty.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to a fixed-latency ALU and
// returns each result on a valid/ready port. Optional counters: ALU_SEQ_STATS_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_in1,
  input  logic [DATA_W-1:0] cmd_in2,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carryout,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_ovf,
  output logic [OP_W-1:0]   rsp_op,
  output logic              busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_cmds,
  output logic [15:0]       stat_carry,
  output logic [15:0]       stat_ovf
`endif
);

  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

  alu_cmd_t          push_cmd;
  alu_cmd_t          head_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              rsp_handshake;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] alu_in1_q;
  logic [DATA_W-1:0] alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q;
  logic [DATA_W-1:0] alu_in2_d;
  logic [OP_W-1:0]   alu_op_q;
  logic [OP_W-1:0]   alu_op_d;
  logic              rsp_valid_q;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_carry_q;
  logic              rsp_carry_d;
  logic              rsp_ovf_q;
  logic              rsp_ovf_d;
  logic [OP_W-1:0]   rsp_op_q;
  logic [OP_W-1:0]   rsp_op_d;

  always_comb begin
    push_cmd     = '0;
    push_cmd.in1 = cmd_in1;
    push_cmd.in2 = cmd_in2;
    push_cmd.op  = cmd_op;
  end

  alu_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(CMD_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .push_data(push_cmd),
    .pop      (fifo_pop),
    .pop_data (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cmd_ready     = !fifo_full;
  assign rsp_handshake = rsp_valid_q && rsp_ready;

  // The result is sampled on the edge where the counter has already reached zero,
  // i.e. ALU_LAT+1 edges after the operands were loaded.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_op_d    = rsp_op_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_in1_d = head_cmd.in1;
          alu_in2_d = head_cmd.in2;
          alu_op_d  = head_cmd.op;
          cnt_d     = LAT_LOAD;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carryout;
          rsp_ovf_d   = alu_overflow;
          rsp_op_d    = alu_op_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_handshake) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_op_q    <= rsp_op_d;
    end
  end

  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_op    = rsp_op_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_cmds_q;
  logic [15:0] stat_cmds_d;
  logic [15:0] stat_carry_q;
  logic [15:0] stat_carry_d;
  logic [15:0] stat_ovf_q;
  logic [15:0] stat_ovf_d;

  // Counted on the response handshake so a reset mid-flight never counts.
  always_comb begin
    stat_cmds_d  = stat_cmds_q;
    stat_carry_d = stat_carry_q;
    stat_ovf_d   = stat_ovf_q;
    if (rsp_handshake) begin
      stat_cmds_d = sat_inc16(stat_cmds_q);
      if (rsp_carry_q) begin
        stat_carry_d = sat_inc16(stat_carry_q);
      end
      if (rsp_ovf_q) begin
        stat_ovf_d = sat_inc16(stat_ovf_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cmds_q  <= '0;
      stat_carry_q <= '0;
      stat_ovf_q   <= '0;
    end else begin
      stat_cmds_q  <= stat_cmds_d;
      stat_carry_q <= stat_carry_d;
      stat_ovf_q   <= stat_ovf_d;
    end
  end

  assign stat_cmds  = stat_cmds_q;
  assign stat_carry = stat_carry_q;
  assign stat_ovf   = stat_ovf_q;
`endif

endmodule
